// File: rtl/minv_pkg.sv
// Shared constants and state encoding for the modular-inverse result unload path.
package minv_pkg;

  // Default result geometry: 256-bit result unloaded as sixteen 16-bit words.
  localparam int MINV_WIDTH  = 256;
  localparam int MINV_WORD   = 16;
  localparam int MINV_NWORDS = MINV_WIDTH / MINV_WORD;

  // Word counter width; one bit minimum so a single-word build still elaborates.
  localparam int MINV_CNT_W  = (MINV_NWORDS > 1) ? $clog2(MINV_NWORDS) : 1;

  // Unload sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } minv_state_e;

endpackage

// File: rtl/rot_reg_256.sv
// Wide holding register: parallel load, rotate-right by one word, synchronous clear.
module rot_reg_256 #(
  parameter int WIDTH = 256,
  parameter int WORD  = 16
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rot_en,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Clear dominates load, load dominates rotate; the low word wraps to the top.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_rot_en) begin
      r_q <= {r_q[WORD-1:0], r_q[WIDTH-1:WORD]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/minv_result_unload.sv
// Parallel-in, word-serial-out unload of a modular-inverse result, low word first.
// After a full unload the register has rotated back to the captured value, so a
// resend replays the same stream without touching din.
module minv_result_unload
  import minv_pkg::*;
#(
  parameter int WIDTH  = MINV_WIDTH,
  parameter int WORD   = MINV_WORD,
  parameter int NWORDS = WIDTH / WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resend,
  input  logic [WIDTH-1:0] din,
  output logic [WORD-1:0]  dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             busy,
  output logic             done
);

  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

  minv_state_e      r_state;
  minv_state_e      w_state_next;
  logic [CW-1:0]    r_count;
  logic             w_load;
  logic             w_rot;
  logic             w_cnt_clr;
  logic [WIDTH-1:0] w_q;

  // Holding register; reset clears it so an aborted unload leaves no stale result.
  rot_reg_256 #(
    .WIDTH (WIDTH),
    .WORD  (WORD)
  ) u_rot_reg (
    .clk      (clk),
    .i_clr    (rst),
    .i_load   (w_load),
    .i_din    (din),
    .i_rot_en (w_rot),
    .o_q      (w_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and register control; start has priority over resend in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_rot        = 1'b0;
    w_cnt_clr    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = SEND;
        end else if (resend) begin
          w_cnt_clr    = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (dout_rdy) begin
          w_rot = 1'b1;
          if (r_count == LAST_IDX) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Word counter: cleared on entry to SEND, advanced on each accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_cnt_clr) begin
      r_count <= '0;
    end else if (w_rot) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Handshake outputs decode the registered state only, so dout_rdy never
  // reaches dout_vld combinationally.
  assign dout     = w_q[WORD-1:0];
  assign dout_vld = (r_state == SEND);
  assign busy     = (r_state == SEND);
  assign done     = (r_state == DONE);

endmodule

// File: tb/tb_minv_result_unload.sv
// Directed bench for minv_result_unload: per-cycle vector table plus
// hand-written multi-cycle sequences (backpressure, injection, reset, round trip).
module tb_minv_result_unload;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         resend;
  logic [255:0] din;
  logic [15:0]  dout;
  logic         dout_vld;
  logic         dout_rdy;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  minv_result_unload dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .resend   (resend),
    .din      (din),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         start;
    logic         resend;
    logic         rdy;
    logic [255:0] din;
    logic         exp_vld;
    logic [15:0]  exp_dout;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  vec_t vecs[36];

  logic [255:0] ramp;
  logic [255:0] ones;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one unload and follow it to the DONE cycle, checking every word,
  // reassembling the stream as the inverse register's cyclic load path would,
  // and optionally injecting an ignored start with all-ones din at word inject_at.
  task automatic unload(input string tag, input logic st, input logic rs,
                        input logic [255:0] d, input logic [255:0] exp_val,
                        input int rdy_mode, input int inject_at,
                        output int send_cycles);
    logic [255:0] inv_reg;
    int           idx;
    logic         xfer;
    logic         injected;
    inv_reg     = '0;
    idx         = 0;
    injected    = 1'b0;
    send_cycles = 0;
    start  = st;
    resend = rs;
    din    = d;
    dout_rdy = 1'b0;
    step();
    start  = 1'b0;
    resend = 1'b0;
    check({tag, "_vld_after_launch"}, dout_vld, 1'b1);
    for (int cyc = 0; cyc < 100 && dout_vld; cyc++) begin
      check($sformatf("%s_word%0d", tag, idx), dout, exp_val[idx*16 +: 16]);
      case (rdy_mode)
        0:       xfer = 1'b1;
        1:       xfer = (cyc % 2 == 0);
        default: xfer = 1'($urandom_range(0, 1));
      endcase
      dout_rdy = xfer;
      if (idx == inject_at && !injected) begin
        start    = 1'b1;
        din      = ones;
        injected = 1'b1;
      end
      if (xfer) inv_reg = {dout, inv_reg[255:16]};
      step();
      start = 1'b0;
      if (xfer) idx++;
      send_cycles++;
      if (idx > 16) break;
    end
    dout_rdy = 1'b0;
    check({tag, "_words_accepted"}, idx, 16);
    check({tag, "_done_pulse"}, done, 1'b1);
    check({tag, "_busy_in_done"}, busy, 1'b0);
    check({tag, "_roundtrip"}, inv_reg, exp_val);
    step();
    check({tag, "_done_cleared"}, done, 1'b0);
    check({tag, "_idle_vld"}, dout_vld, 1'b0);
  endtask

  initial begin
    int sc;
    logic [255:0] rnd;
    logic [255:0] prio;

    ones = '1;
    for (int k = 0; k < 16; k++) ramp[k*16 +: 16] = 16'(k);
    for (int k = 0; k < 16; k++) prio[k*16 +: 16] = 16'(16'h0100 + k);

    // Basic unload followed by resend with all-ones din (must not be captured).
    for (int i = 0; i < 36; i++) begin
      vecs[i] = '{start: 1'b0, resend: 1'b0, rdy: 1'b1, din: ramp,
                  exp_vld: 1'b1, exp_dout: 16'h0, exp_busy: 1'b1, exp_done: 1'b0};
    end
    vecs[0].start = 1'b1;
    for (int i = 1; i < 16; i++) vecs[i].exp_dout = 16'(i);
    vecs[16].exp_vld = 1'b0; vecs[16].exp_busy = 1'b0; vecs[16].exp_done = 1'b1;
    vecs[17].exp_vld = 1'b0; vecs[17].exp_busy = 1'b0;
    for (int i = 18; i < 36; i++) vecs[i].din = ones;
    vecs[18].resend = 1'b1;
    for (int i = 19; i < 34; i++) vecs[i].exp_dout = 16'(i - 18);
    vecs[34].exp_vld = 1'b0; vecs[34].exp_busy = 1'b0; vecs[34].exp_done = 1'b1;
    vecs[35].exp_vld = 1'b0; vecs[35].exp_busy = 1'b0;

    // Reset state.
    rst = 1'b1; start = 1'b0; resend = 1'b0; din = '0; dout_rdy = 1'b0;
    step();
    step();
    check("reset_vld",  dout_vld, 1'b0);
    check("reset_busy", busy,     1'b0);
    check("reset_done", done,     1'b0);
    check("reset_dout", dout,     16'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 36; i++) begin
      start    = vecs[i].start;
      resend   = vecs[i].resend;
      dout_rdy = vecs[i].rdy;
      din      = vecs[i].din;
      step();
      check($sformatf("vec%0d_vld", i),  dout_vld, vecs[i].exp_vld);
      check($sformatf("vec%0d_dout", i), dout,     vecs[i].exp_dout);
      check($sformatf("vec%0d_busy", i), busy,     vecs[i].exp_busy);
      check($sformatf("vec%0d_done", i), done,     vecs[i].exp_done);
    end
    start = 1'b0; resend = 1'b0; dout_rdy = 1'b0;
    step();

    // Backpressure: ready on alternate cycles, 31 SEND cycles in total.
    unload("bp", 1'b1, 1'b0, ramp, ramp, 1, -1, sc);
    check("bp_send_cycles", sc, 31);

    // Start with all-ones din at word 5 is ignored.
    unload("inj", 1'b1, 1'b0, ramp, ramp, 0, 5, sc);
    check("inj_send_cycles", sc, 16);

    // Start and resend together: start wins and din is captured.
    unload("prio", 1'b1, 1'b1, prio, prio, 0, -1, sc);

    // Reset after word 7 aborts the unload and clears the register.
    start = 1'b1; din = ramp;
    step();
    start = 1'b0; dout_rdy = 1'b1;
    for (int k = 0; k < 8; k++) step();
    check("mid_dout_before_rst", dout, 16'h0008);
    rst = 1'b1; dout_rdy = 1'b0;
    step();
    rst = 1'b0;
    check("rst_mid_vld",  dout_vld, 1'b0);
    check("rst_mid_busy", busy,     1'b0);
    check("rst_mid_done", done,     1'b0);
    check("rst_mid_dout", dout,     16'h0);
    step();
    check("rst_mid_no_done", done, 1'b0);
    unload("zero", 1'b0, 1'b1, ones, '0, 0, -1, sc);

    // Round trip with random results and random backpressure.
    for (int t = 0; t < 3; t++) begin
      for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom;
      unload($sformatf("rt%0d", t), 1'b1, 1'b0, rnd, rnd, 2, -1, sc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
